// File: rtl/pattern_round_ctrl.sv
// Round controller for the switch-pattern memory game.
// The controller shows a pseudo-random target on the LEDs for a fixed window.
// It then waits for the player's submit (or a timeout) and judges the guess.
// It emits one-cycle hit/miss pulses and keeps track of rounds, lives and game over.
//
// Handshake note: there is no valid/ready traffic on this block. Buttons are
// level inputs turned into single-cycle strobes. hit/miss are single-cycle
// qualifiers that the score path consumes unconditionally (no backpressure).
module pattern_round_ctrl #(
    parameter int          SHOW_TICKS  = 200,
    parameter int          GUESS_TICKS = 1000,
    parameter int          LIVES       = 3,
    parameter logic [7:0]  SEED        = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       submit,
    input  logic [7:0] guess,
    output logic [7:0] target,
    output logic       show,
    output logic       hit,
    output logic       miss,
    output logic [2:0] lives_left,
    output logic [7:0] round,
    output logic       game_over,
    output logic [2:0] dbg_state
);

    localparam int MAX_T = (SHOW_TICKS > GUESS_TICKS) ? SHOW_TICKS : GUESS_TICKS;
    localparam int TW    = (MAX_T > 2) ? $clog2(MAX_T) : 1;
    localparam logic [TW-1:0] SHOW_LOAD  = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] GUESS_LOAD = TW'(GUESS_TICKS - 1);
    localparam logic [7:0]    SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHOW  = 3'd2,
        ST_GUESS = 3'd3,
        ST_JUDGE = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    state_t        state, next_state;
    logic [7:0]    lfsr;
    logic [TW-1:0] timer;
    logic          start_s1, start_s2, start_s3, start_stb;
    logic          submit_s1, submit_s2, submit_s3, submit_stb;
    logic          load_target, load_show, load_guess, dec_timer;
    logic          judge_hit, judge_miss, restart;

    // Button synchronisers with registered rising-edge strobes (held buttons do not repeat)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_s1   <= 1'b0;
            start_s2   <= 1'b0;
            start_s3   <= 1'b0;
            start_stb  <= 1'b0;
            submit_s1  <= 1'b0;
            submit_s2  <= 1'b0;
            submit_s3  <= 1'b0;
            submit_stb <= 1'b0;
        end else begin
            start_s1   <= start;
            start_s2   <= start_s1;
            start_s3   <= start_s2;
            start_stb  <= start_s2 & ~start_s3;
            submit_s1  <= submit;
            submit_s2  <= submit_s1;
            submit_s3  <= submit_s2;
            submit_stb <= submit_s2 & ~submit_s3;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state and datapath control; the guess is judged on the GUESS->JUDGE edge
    always_comb begin
        next_state  = state;
        load_target = 1'b0;
        load_show   = 1'b0;
        load_guess  = 1'b0;
        dec_timer   = 1'b0;
        judge_hit   = 1'b0;
        judge_miss  = 1'b0;
        restart     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_stb) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                load_target = 1'b1;
                load_show   = 1'b1;
                next_state  = ST_SHOW;
            end
            ST_SHOW: begin
                if (timer == '0) begin
                    load_guess = 1'b1;
                    next_state = ST_GUESS;
                end else begin
                    dec_timer = 1'b1;
                end
            end
            ST_GUESS: begin
                // A submit in the expiry cycle beats the timeout
                if (submit_stb) begin
                    next_state = ST_JUDGE;
                    if (guess == target) judge_hit  = 1'b1;
                    else                 judge_miss = 1'b1;
                end else if (timer == '0) begin
                    next_state = ST_JUDGE;
                    judge_miss = 1'b1;
                end else begin
                    dec_timer = 1'b1;
                end
            end
            ST_JUDGE: begin
                if (hit) begin
                    next_state = ST_LOAD;
                end else if (lives_left == 3'd0) begin
                    next_state = ST_OVER;
                end else begin
                    load_show  = 1'b1;
                    next_state = ST_SHOW;
                end
            end
            ST_OVER: begin
                if (start_stb) begin
                    restart    = 1'b1;
                    next_state = ST_LOAD;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // LFSR, target, timer, result pulses and round/lives counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= SEED_EFF;
            target     <= 8'h00;
            timer      <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            round      <= 8'h00;
            lives_left <= LIVES_INIT;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            hit  <= judge_hit;
            miss <= judge_miss;
            if (load_target) target <= lfsr;
            if (load_show)       timer <= SHOW_LOAD;
            else if (load_guess) timer <= GUESS_LOAD;
            else if (dec_timer)  timer <= timer - TW'(1);
            if (judge_hit && round != 8'hFF)     round      <= round + 8'd1;
            if (judge_miss && lives_left != 3'd0) lives_left <= lives_left - 3'd1;
            if (restart) begin
                round      <= 8'h00;
                lives_left <= LIVES_INIT;
            end
        end
    end

    assign show      = (state == ST_SHOW);
    assign game_over = (state == ST_OVER);
    assign dbg_state = state;

endmodule

// File: tb/tb_pattern_round_ctrl.sv
// Bench for pattern_round_ctrl: random rounds against a round-level reference model.
module tb_pattern_round_ctrl;
  localparam int         SHOW_T  = 4;
  localparam int         GUESS_T = 64;
  localparam int         LIVES_N = 3;
  localparam logic [7:0] SEED_V  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, submit;
  logic [7:0] guess;
  logic [7:0] target;
  logic       show, hit, miss;
  logic [2:0] lives_left;
  logic [7:0] round;
  logic       game_over;
  logic [2:0] dbg_state;

  pattern_round_ctrl #(
    .SHOW_TICKS(SHOW_T), .GUESS_TICKS(GUESS_T), .LIVES(LIVES_N), .SEED(SEED_V)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .submit(submit), .guess(guess),
    .target(target), .show(show), .hit(hit), .miss(miss),
    .lives_left(lives_left), .round(round), .game_over(game_over),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter / reference LFSR ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
    return {v[6:0], ^(v & 8'b1011_1000)};
  endfunction

  logic [7:0] lfsr_m, lfsr_before;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m      <= SEED_V;
      lfsr_before <= SEED_V;
    end else begin
      lfsr_before <= lfsr_m;
      lfsr_m      <= lfsr_step(lfsr_m);
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [33:0] exp_q[$];   // {kind(2'b10 hit / 2'b01 miss), pulse cycle}
  logic [33:0] mon_e;

  int         m_round;
  int         m_lives;
  logic [7:0] m_target;
  bit         m_new_round;
  int         exp_show_cyc;

  task automatic check_eq(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pulse monitor: every hit/miss must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (hit || miss)) begin
      check_eq("hit_miss_exclusive", {33'd0, hit & miss}, 34'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pulse", {32'd0, hit, miss}, 34'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("pulse_kind", {32'd0, hit, miss}, {32'd0, mon_e[33:32]});
        check_eq("pulse_cycle", 34'(cyc), {2'b00, mon_e[31:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string where);
    check_eq({where, "_target"},    34'(target), 34'd0);
    check_eq({where, "_show"},      34'(show), 34'd0);
    check_eq({where, "_hit"},       34'(hit), 34'd0);
    check_eq({where, "_miss"},      34'(miss), 34'd0);
    check_eq({where, "_lives"},     34'(lives_left), 34'(LIVES_N));
    check_eq({where, "_round"},     34'(round), 34'd0);
    check_eq({where, "_game_over"}, 34'(game_over), 34'd0);
  endtask

  task automatic press_start();
    @(negedge clk);
    start = 1'b1;
    exp_show_cyc = cyc + 5;   // sampled at +1, strobe acts at +4 (LOAD), SHOW from +5
    repeat ($urandom_range(1, 3)) @(negedge clk);
    start = 1'b0;
    m_new_round = 1'b1;
  endtask

  task automatic wait_show_rise(output int ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (show === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // kind: 0 correct, 1 wrong, 2 timeout, 3 correct on expiry cycle,
  //       4 wrong with submit held 50 cycles, 5 reset mid-guess
  task automatic do_round(input int kind);
    int ok, s, g, cnt, d, h, n, p;
    bit is_hit;
    logic [7:0] gv;
    wait_show_rise(ok);
    check_eq("show_rise_seen", 34'(ok), 34'd1);
    if (ok == 0) return;
    s = cyc;
    if (exp_show_cyc >= 0) check_eq("show_latency", 34'(s), 34'(exp_show_cyc));
    if (m_new_round) m_target = lfsr_before;
    check_eq("target_at_show", 34'(target), 34'(m_target));
    check_eq("lives_at_show", 34'(lives_left), 34'(m_lives));
    check_eq("round_at_show", 34'(round), 34'(m_round));
    // Noise during SHOW: submit and start strobes here must have no effect
    submit = ($urandom_range(0, 1) == 1);
    start  = ($urandom_range(0, 3) == 0);
    cnt = 0;
    while (show === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
      submit = 1'b0;
      start  = 1'b0;
    end
    check_eq("show_len", 34'(cnt), 34'(SHOW_T));
    g = cyc;
    check_eq("target_held", 34'(target), 34'(m_target));

    if (kind == 5) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      exp_q.delete();
      m_lives = LIVES_N;
      m_round = 0;
      repeat (2) @(negedge clk);
      check_reset_outputs("held_reset");
      rst_n = 1'b1;
      exp_show_cyc = -1;
      return;
    end

    is_hit = (kind == 0 || kind == 3);
    if (kind == 2) begin
      guess = 8'($urandom_range(0, 255));
      p = g + GUESS_T;
      exp_q.push_back({2'b01, 32'(p)});
    end else begin
      gv = is_hit ? m_target : (m_target ^ 8'($urandom_range(1, 255)));
      guess = gv;
      d = (kind == 3) ? (GUESS_T - 4) : $urandom_range(0, 8);
      h = (kind == 4) ? 50 : $urandom_range(1, 3);
      repeat (d) @(negedge clk);
      submit = 1'b1;
      n = cyc;
      p = n + 4;
      exp_q.push_back({is_hit ? 2'b10 : 2'b01, 32'(p)});
      repeat (h) @(negedge clk);
      submit = 1'b0;
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("pulse_arrived", 34'(exp_q.size()), 34'd0);
    exp_q.delete();

    if (is_hit) begin
      m_round = (m_round < 255) ? m_round + 1 : 255;
      m_new_round = 1'b1;
      exp_show_cyc = p + 2;   // JUDGE -> LOAD -> SHOW
    end else begin
      m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      m_new_round = 1'b0;
      exp_show_cyc = p + 1;   // JUDGE -> SHOW replay
    end

    @(negedge clk);
    check_eq("lives_after", 34'(lives_left), 34'(m_lives));
    check_eq("round_after", 34'(round), 34'(m_round));
    check_eq("game_over_after", 34'(game_over), 34'(m_lives == 0));
    if (m_lives == 0) check_eq("target_in_over", 34'(target), 34'(m_target));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    submit = 1'b0;
    guess = 8'h00;
    exp_show_cyc = -1;
    m_lives = LIVES_N;
    m_round = 0;
    m_target = 8'h00;
    m_new_round = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("idle");

    // Directed: hits, wrong guess, timeout, expiry-cycle submit, held submit into game over
    press_start();
    do_round(0);
    do_round(0);
    do_round(1);
    do_round(2);
    do_round(3);
    do_round(4);
    repeat (5) @(negedge clk);
    check_eq("over_persists", 34'(game_over), 34'd1);
    check_eq("over_no_show", 34'(show), 34'd0);
    check_eq("over_lives_zero", 34'(lives_left), 34'd0);

    // Restart from game over
    m_lives = LIVES_N;
    m_round = 0;
    press_start();

    // Random rounds that never exhaust the lives
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 3);
      if (m_lives == 1 && (k == 1 || k == 2)) k = 0;
      do_round(k);
    end

    // Reset in the middle of a guess, then restart
    do_round(5);
    repeat (2) @(negedge clk);
    check_reset_outputs("after_reset");
    press_start();

    // Enough hits to saturate the round counter
    for (int i = 0; i < 260; i++) do_round(0);
    check_eq("round_saturated", 34'(round), 34'd255);

    repeat (4) @(negedge clk);
    check_eq("queue_drained", 34'(exp_q.size()), 34'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time guard
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule
